// File: rtl/uart_frame_sender.sv
// Frame sender: streams SYNC, 16-bit length, payload read from memory and an XOR checksum to the uart.
// Latency: first oTxSend one cycle after an accepted start; next byte 1 cycle (header/CSUM) or 2 cycles (payload) after iTxDone.
// Backpressure: one byte in flight; each byte waits for the uart's iTxDone before the next is issued.
module uart_frame_sender #(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iStartSignal,
  input  logic [ADDR_WIDTH-1:0] iLength,
  input  logic                  iTxDone,
  input  logic [7:0]            iMemData,
  output logic [ADDR_WIDTH-1:0] oAddress,
  output logic [7:0]            oTxData,
  output logic                  oTxSend,
  output logic                  oBusy,
  output logic                  oFinished
);

  // Byte states issue a write strobe; each is followed by its own wait state
  // so the wait knows which byte comes next without extra bookkeeping.
  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_WAIT_SYNC,
    S_LEN_HI,
    S_WAIT_LEN_HI,
    S_LEN_LO,
    S_WAIT_LEN_LO,
    S_FETCH,
    S_DATA,
    S_WAIT_DATA,
    S_CSUM,
    S_WAIT_CSUM,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  // Datapath registers
  logic [ADDR_WIDTH-1:0] len_q, len_d;    // payload length latched at start
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;    // payload bytes already written
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;  // memory read address
  logic [7:0]            csum_q, csum_d;  // running XOR of payload bytes
  logic [7:0]            txd_q, txd_d;    // last byte written, held during waits

  // The length is always sent as two bytes, resized to 16 bits.
  logic [15:0] len16;
  assign len16 = 16'(len_q);

  logic       start_ok;
  logic       send_vld;
  logic [7:0] send_dat;
  logic       last_byte;

  assign start_ok  = (state_q == S_IDLE) && iStartSignal;
  // cnt_q already includes the byte just written, so equality means the payload is complete.
  assign last_byte = (cnt_q == len_q);

  // State register; reset aborts any frame in progress immediately.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; iTxDone only counts in wait states, so a done pulse in a
  // strobe cycle (belonging to an earlier byte) or in IDLE is dropped.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:        if (iStartSignal) state_d = S_SYNC;
      S_SYNC:        state_d = S_WAIT_SYNC;
      S_WAIT_SYNC:   if (iTxDone) state_d = S_LEN_HI;
      S_LEN_HI:      state_d = S_WAIT_LEN_HI;
      S_WAIT_LEN_HI: if (iTxDone) state_d = S_LEN_LO;
      S_LEN_LO:      state_d = S_WAIT_LEN_LO;
      S_WAIT_LEN_LO: begin
        if (iTxDone) state_d = (len_q != '0) ? S_FETCH : S_CSUM;
      end
      S_FETCH:       state_d = S_DATA;
      S_DATA:        state_d = S_WAIT_DATA;
      S_WAIT_DATA: begin
        if (iTxDone) state_d = last_byte ? S_CSUM : S_FETCH;
      end
      S_CSUM:        state_d = S_WAIT_CSUM;
      S_WAIT_CSUM:   if (iTxDone) state_d = S_DONE;
      S_DONE:        state_d = S_IDLE;
      default:       state_d = S_IDLE;
    endcase
  end

  // Output decode; in strobe states the byte is driven directly so the uart
  // sees it in the same cycle as oTxSend, otherwise the held copy is shown.
  always_comb begin
    send_vld  = 1'b0;
    send_dat  = txd_q;
    oBusy     = 1'b1;
    oFinished = 1'b0;
    unique case (state_q)
      S_IDLE: oBusy = 1'b0;
      S_SYNC: begin
        send_vld = 1'b1;
        send_dat = SYNC_BYTE;
      end
      S_LEN_HI: begin
        send_vld = 1'b1;
        send_dat = len16[15:8];
      end
      S_LEN_LO: begin
        send_vld = 1'b1;
        send_dat = len16[7:0];
      end
      S_DATA: begin
        send_vld = 1'b1;
        send_dat = iMemData;
      end
      S_CSUM: begin
        send_vld = 1'b1;
        send_dat = csum_q;
      end
      S_DONE: begin
        oBusy     = 1'b0;
        oFinished = 1'b1;
      end
      default: ;
    endcase
  end

  assign oTxSend  = send_vld;
  assign oTxData  = send_dat;
  assign oAddress = addr_q;

  // Datapath next-state: latch length and restart counters on start, fold each
  // payload byte into the checksum, advance the address only between payload bytes.
  always_comb begin
    len_d  = len_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    csum_d = csum_q;
    txd_d  = txd_q;
    if (start_ok) begin
      len_d  = iLength;
      cnt_d  = '0;
      addr_d = '0;
      csum_d = 8'h00;
    end
    if (send_vld) begin
      txd_d = send_dat;
    end
    if (state_q == S_DATA) begin
      csum_d = csum_q ^ iMemData;
      cnt_d  = cnt_q + 1'b1;
    end
    // Address stops at length-1, so a 0xFFFF frame never wraps.
    if ((state_q == S_WAIT_DATA) && iTxDone && !last_byte) begin
      addr_d = addr_q + 1'b1;
    end
  end

  // Datapath registers.
  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      len_q  <= '0;
      cnt_q  <= '0;
      addr_q <= '0;
      csum_q <= 8'h00;
      txd_q  <= 8'h00;
    end else begin
      len_q  <= len_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      csum_q <= csum_d;
      txd_q  <= txd_d;
    end
  end

endmodule
